// File: rtl/alu_exec_ctrl_if.sv
// Issue/writeback bundle between register-read, the ALU sequencer and the register-file write port.
// master drives instructions and consumes results; slave is the sequencer.
interface alu_exec_ctrl_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;
    logic            wb_illegal;

    modport master (
        output in_valid, instr, rs1_data, rs2_data, wb_ready,
        input  in_ready, wb_valid, wb_rd, wb_data, wb_we, wb_illegal
    );

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, wb_ready,
        output in_ready, wb_valid, wb_rd, wb_data, wb_we, wb_illegal
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// RV32I OP/OP-IMM execute sequencer: one op in flight, shifts one bit per cycle.
// Latency: 2 cycles to wb_valid (2+n for shift by n); in_ready only in IDLE, result held until wb_ready.
module alu_exec_ctrl #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    alu_exec_ctrl_if.slave       bus,
    output logic                 busy
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
        S_WB
    } state_e;

    state_e             state_q, state_d;
    logic [6:0]         opc_q, opc_d;
    logic [2:0]         f3_q, f3_d;
    logic [6:0]         f7_q, f7_d;
    logic [4:0]         rd_q, rd_d;
    logic [XLEN-1:0]    rs1_q, rs1_d;
    logic [XLEN-1:0]    op2_q, op2_d;
    logic [XLEN-1:0]    acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic               wb_we_q, wb_we_d;
    logic               wb_ill_q, wb_ill_d;

    logic               is_op, is_imm, illegal, is_shift;
    logic [XLEN-1:0]    alu_res, acc_step;

    assign is_op  = (opc_q == OPC_OP);
    assign is_imm = (opc_q == OPC_OP_IMM);
    assign is_shift = (f3_q == 3'b001) || (f3_q == 3'b101);

    always_comb begin
        illegal = 1'b0;
        if (!is_op && !is_imm)
            illegal = 1'b1;
        else if (is_op && (f7_q != F7_ZERO) && (f7_q != F7_ALT))
            illegal = 1'b1;
        else if (is_op && (f7_q == F7_ALT) && (f3_q != 3'b000) && (f3_q != 3'b101))
            illegal = 1'b1;
        else if (is_imm && (f3_q == 3'b001) && (f7_q != F7_ZERO))
            illegal = 1'b1;
        else if (is_imm && (f3_q == 3'b101) && (f7_q != F7_ZERO) && (f7_q != F7_ALT))
            illegal = 1'b1;
    end

    always_comb begin
        alu_res = '0;
        case (f3_q)
            3'b000:  alu_res = (is_op && f7_q == F7_ALT) ? rs1_q - op2_q : rs1_q + op2_q;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_q) < $signed(op2_q)};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, rs1_q < op2_q};
            3'b100:  alu_res = rs1_q ^ op2_q;
            3'b110:  alu_res = rs1_q | op2_q;
            3'b111:  alu_res = rs1_q & op2_q;
            default: alu_res = '0;
        endcase
    end

    // f7 bit 5 distinguishes SRA/SRAI from the logical right shift.
    assign acc_step = (f3_q == 3'b001) ? {acc_q[XLEN-2:0], 1'b0}
                                       : {f7_q[5] & acc_q[XLEN-1], acc_q[XLEN-1:1]};

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        f3_d      = f3_q;
        f7_d      = f7_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        op2_d     = op2_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        wb_we_d   = wb_we_q;
        wb_ill_d  = wb_ill_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && !flush) begin
                    opc_d   = bus.instr[6:0];
                    f3_d    = bus.instr[14:12];
                    f7_d    = bus.instr[31:25];
                    rd_d    = bus.instr[11:7];
                    rs1_d   = bus.rs1_data;
                    op2_d   = (bus.instr[6:0] == OPC_OP_IMM)
                              ? {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]}
                              : bus.rs2_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                wb_rd_d = rd_q;
                if (illegal) begin
                    wb_data_d = '0;
                    wb_we_d   = 1'b0;
                    wb_ill_d  = 1'b1;
                    state_d   = S_WB;
                end else begin
                    wb_we_d  = (rd_q != 5'd0);
                    wb_ill_d = 1'b0;
                    if (is_shift) begin
                        acc_d = rs1_q;
                        cnt_d = op2_q[SHAMT_W-1:0];
                        if (op2_q[SHAMT_W-1:0] == '0) begin
                            wb_data_d = rs1_q;
                            state_d   = S_WB;
                        end else begin
                            state_d   = S_SHIFT;
                        end
                    end else begin
                        wb_data_d = alu_res;
                        state_d   = S_WB;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                    wb_data_d = acc_step;
                    state_d   = S_WB;
                end
            end
            S_WB: begin
                if (bus.wb_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides every transition, including a same-cycle writeback accept.
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            opc_q     <= '0;
            f3_q      <= '0;
            f7_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            op2_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_ill_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            f3_q      <= f3_d;
            f7_q      <= f7_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            op2_q     <= op2_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            wb_we_q   <= wb_we_d;
            wb_ill_q  <= wb_ill_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.wb_valid   = (state_q == S_WB);
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_we      = (state_q == S_WB) ? wb_we_q : 1'b0;
    assign bus.wb_illegal = wb_ill_q;
    assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: directed cases plus random ops against a behavioural RV32I model.
module tb_alu_exec_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    alu_exec_ctrl_if #(.XLEN(32)) bus ();

    alu_exec_ctrl #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    // Architectural RV32I result; lat counts cycles from the cycle after acceptance to first wb_valid.
    function automatic void model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic ill, output logic we, output int lat);
        logic       op_r, op_i, legal;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] y;
        int unsigned sh;
        op_r = (ins[6:0] == 7'b0110011);
        op_i = (ins[6:0] == 7'b0010011);
        f3   = ins[14:12];
        f7   = ins[31:25];
        y    = op_i ? {{20{ins[31]}}, ins[31:20]} : b;
        sh   = y[4:0];
        if (op_r)
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (op_i && f3 == 3'd1)
            legal = (f7 == 7'h00);
        else if (op_i && f3 == 3'd5)
            legal = (f7 == 7'h00) || (f7 == 7'h20);
        else
            legal = op_i;
        d   = 32'd0;
        lat = 1;
        ill = !legal;
        we  = legal && (ins[11:7] != 5'd0);
        if (!legal) return;
        case (f3)
            3'd0: d = (op_r && f7 == 7'h20) ? a - y : a + y;
            3'd1: begin d = a << sh; lat = 1 + sh; end
            3'd2: d = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: d = (a < y) ? 32'd1 : 32'd0;
            3'd4: d = a ^ y;
            3'd5: begin d = f7[5] ? 32'($signed(a) >>> sh) : a >> sh; lat = 1 + sh; end
            3'd6: d = a | y;
            default: d = a & y;
        endcase
    endfunction

    // Issues one op and waits for wb_valid without accepting it.
    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_ok, output bit tmo);
        int w;
        w = 0;
        tmo = 0;
        busy_ok = 1;
        while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs1_data = a;
        bus.rs2_data = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.instr    = $urandom;
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        lat = 0;
        while (!bus.wb_valid && lat < 60) begin
            if (!busy) busy_ok = 0;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.wb_valid) tmo = 1;
    endtask

    task automatic accept();
        bus.wb_ready = 1'b1;
        @(posedge clk); #1;
        bus.wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
        total_cnt++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_illegal, busy} !== 4'b0)
            $display("FAIL reset_flags got v=%b we=%b ill=%b busy=%b want all 0", bus.wb_valid, bus.wb_we, bus.wb_illegal, busy);
        else pass_cnt++;
        total_cnt++;
        if ({bus.wb_data, bus.wb_rd} !== 37'd0) $display("FAIL reset_data got data=%h rd=%0d want 0", bus.wb_data, bus.wb_rd);
        else pass_cnt++;
    endtask

    task automatic test_arith();
        int lat; bit bok, tmo;
        send(rtype(7'h00, 3'd0, 5'd3), 32'h7FFF_FFFF, 32'd1, lat, bok, tmo);
        total_cnt++; if (tmo || lat != 1) $display("FAIL add_latency got %0d (tmo=%0b) want 1", lat, tmo); else pass_cnt++;
        total_cnt++; if (bus.wb_data !== 32'h8000_0000) $display("FAIL add_data got %h want 80000000", bus.wb_data); else pass_cnt++;
        total_cnt++;
        if (bus.wb_rd !== 5'd3 || bus.wb_we !== 1'b1 || bus.wb_illegal !== 1'b0)
            $display("FAIL add_ctrl got rd=%0d we=%b ill=%b want rd=3 we=1 ill=0", bus.wb_rd, bus.wb_we, bus.wb_illegal);
        else pass_cnt++;
        accept();
        send(rtype(7'h20, 3'd0, 5'd4), 32'd5, 32'd7, lat, bok, tmo);
        total_cnt++; if (bus.wb_data !== 32'hFFFF_FFFE) $display("FAIL sub_data got %h want fffffffe", bus.wb_data); else pass_cnt++;
        accept();
        send(rtype(7'h00, 3'd2, 5'd5), 32'd5, 32'hFFFF_FFFF, lat, bok, tmo);
        total_cnt++; if (bus.wb_data !== 32'd0) $display("FAIL slt_data got %h want 0", bus.wb_data); else pass_cnt++;
        accept();
        send(rtype(7'h00, 3'd3, 5'd6), 32'd5, 32'hFFFF_FFFF, lat, bok, tmo);
        total_cnt++; if (bus.wb_data !== 32'd1) $display("FAIL sltu_data got %h want 1", bus.wb_data); else pass_cnt++;
        accept();
        send(itype(12'hFFF, 3'd3, 5'd7), 32'd0, 32'd0, lat, bok, tmo);
        total_cnt++; if (bus.wb_data !== 32'd1) $display("FAIL sltiu_data got %h want 1", bus.wb_data); else pass_cnt++;
        accept();
    endtask

    task automatic test_shift();
        int lat; bit bok, tmo;
        send(itype({7'h20, 5'd31}, 3'd5, 5'd8), 32'h8000_0000, 32'd0, lat, bok, tmo);
        total_cnt++; if (tmo || lat != 32) $display("FAIL srai31_latency got %0d (tmo=%0b) want 32", lat, tmo); else pass_cnt++;
        total_cnt++; if (bus.wb_data !== 32'hFFFF_FFFF) $display("FAIL srai31_data got %h want ffffffff", bus.wb_data); else pass_cnt++;
        total_cnt++; if (!bok) $display("FAIL srai31_busy got low during op want high"); else pass_cnt++;
        accept();
        send(itype(12'd0, 3'd1, 5'd9), 32'h1234, 32'd0, lat, bok, tmo);
        total_cnt++; if (tmo || lat != 1) $display("FAIL slli0_latency got %0d want 1", lat); else pass_cnt++;
        total_cnt++; if (bus.wb_data !== 32'h1234) $display("FAIL slli0_data got %h want 1234", bus.wb_data); else pass_cnt++;
        accept();
    endtask

    task automatic test_backpressure();
        int lat; bit bok, tmo; int bad;
        send(rtype(7'h00, 3'd4, 5'd10), 32'hF0F0_1234, 32'h0FF0_FFFF, lat, bok, tmo);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hFF00_EDCB || bus.in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        total_cnt++; if (bad != 0) $display("FAIL stall_hold got %0d unstable cycles want 0 (data=%h)", bad, bus.wb_data); else pass_cnt++;
        accept();
        total_cnt++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL stall_release got valid=%b in_ready=%b want 0/1", bus.wb_valid, bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        int lat; bit bok, tmo;
        send({12'd0, 5'd1, 3'd0, 5'd4, 7'b0000011}, 32'd9, 32'd9, lat, bok, tmo);
        total_cnt++;
        if (tmo || bus.wb_illegal !== 1'b1 || bus.wb_we !== 1'b0 || bus.wb_data !== 32'd0)
            $display("FAIL ill_opcode got ill=%b we=%b data=%h want 1/0/0", bus.wb_illegal, bus.wb_we, bus.wb_data);
        else pass_cnt++;
        accept();
        send(rtype(7'h20, 3'd4, 5'd4), 32'd9, 32'd3, lat, bok, tmo);
        total_cnt++;
        if (tmo || bus.wb_illegal !== 1'b1 || bus.wb_we !== 1'b0 || bus.wb_data !== 32'd0)
            $display("FAIL ill_f7alt_xor got ill=%b we=%b data=%h want 1/0/0", bus.wb_illegal, bus.wb_we, bus.wb_data);
        else pass_cnt++;
        accept();
        send(itype({7'h20, 5'd3}, 3'd1, 5'd4), 32'd9, 32'd3, lat, bok, tmo);
        total_cnt++; if (bus.wb_illegal !== 1'b1) $display("FAIL ill_slli_f7 got %b want 1", bus.wb_illegal); else pass_cnt++;
        accept();
    endtask

    task automatic test_rd0();
        int lat; bit bok, tmo;
        send(itype(12'd5, 3'd0, 5'd0), 32'd10, 32'd0, lat, bok, tmo);
        total_cnt++;
        if (tmo || bus.wb_we !== 1'b0 || bus.wb_data !== 32'd15)
            $display("FAIL rd0 got we=%b data=%h want we=0 data=f", bus.wb_we, bus.wb_data);
        else pass_cnt++;
        accept();
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rd0_done got in_ready=%b want 1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_flush();
        int seen; int lat; bit bok, tmo;
        seen = 0;
        bus.in_valid = 1'b1; bus.instr = rtype(7'h00, 3'd1, 5'd11); bus.rs1_data = 32'd1; bus.rs2_data = 32'd20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; if (bus.wb_valid) seen++; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL flush_idle got busy=%b in_ready=%b want 0/1", busy, bus.in_ready);
        else pass_cnt++;
        repeat (30) begin @(posedge clk); #1; if (bus.wb_valid) seen++; end
        total_cnt++; if (seen != 0) $display("FAIL flush_no_wb got %0d valid cycles want 0", seen); else pass_cnt++;
        bus.in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; flush = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_blocks_accept got busy=%b want 0", busy); else pass_cnt++;
        send(rtype(7'h00, 3'd6, 5'd12), 32'h10, 32'h01, lat, bok, tmo);
        bus.wb_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        bus.wb_ready = 1'b0; flush = 1'b0;
        total_cnt++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL flush_in_wb got valid=%b in_ready=%b want 0/1", bus.wb_valid, bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        int lat; bit bok, tmo;
        send(rtype(7'h00, 3'd0, 5'd13), 32'd100, 32'd23, lat, bok, tmo);
        accept();
        bus.in_valid = 1'b1; bus.instr = rtype(7'h00, 3'd1, 5'd14); bus.rs1_data = 32'd1; bus.rs2_data = 32'd20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_illegal, busy} !== 4'b0 || bus.wb_data !== 32'd0 || bus.wb_rd !== 5'd0 || bus.in_ready !== 1'b1)
            $display("FAIL rst_mid_shift got v=%b we=%b data=%h rd=%0d busy=%b rdy=%b want reset values",
                     bus.wb_valid, bus.wb_we, bus.wb_data, bus.wb_rd, busy, bus.in_ready);
        else pass_cnt++;
        send(rtype(7'h00, 3'd0, 5'd15), 32'd1, 32'd2, lat, bok, tmo);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if (bus.wb_valid !== 1'b0 || bus.wb_data !== 32'd0 || bus.wb_rd !== 5'd0)
            $display("FAIL rst_mid_wb got v=%b data=%h rd=%0d want 0", bus.wb_valid, bus.wb_data, bus.wb_rd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.in_valid = 1'b1; bus.instr = rtype(7'h00, 3'd7, 5'd16); bus.rs1_data = 32'hFF00; bus.rs2_data = 32'h0FF0;
        @(posedge clk); #1;
        bus.instr = itype(12'h7FF, 3'd0, 5'd17); bus.rs1_data = 32'd1;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.wb_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.wb_data !== 32'h0F00)
            $display("FAIL b2b_first got v=%b rdy=%b data=%h want 1/0/00000f00", bus.wb_valid, bus.in_ready, bus.wb_data);
        else pass_cnt++;
        bus.wb_ready = 1'b1;
        @(posedge clk); #1;
        bus.wb_ready = 1'b0;
        total_cnt++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL b2b_gap got v=%b rdy=%b want 0/1", bus.wb_valid, bus.in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.wb_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        total_cnt++;
        if (lat != 1 || bus.wb_data !== 32'h800 || bus.wb_rd !== 5'd17)
            $display("FAIL b2b_second got lat=%0d data=%h rd=%0d want 1/00000800/17", lat, bus.wb_data, bus.wb_rd);
        else pass_cnt++;
        accept();
    endtask

    task automatic test_random();
        int lat, elat; bit bok, tmo;
        logic [31:0] ins, a, b, ed;
        logic eill, ewe;
        logic [6:0] f7;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: f7 = 7'h00;
                3, 4:    f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            ins = $urandom;
            if ($urandom_range(0, 9) < 5) ins[6:0] = 7'b0110011;
            else if ($urandom_range(0, 8) != 0) ins[6:0] = 7'b0010011;
            ins[31:25] = f7;
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b = $urandom;
            model(ins, a, b, ed, eill, ewe, elat);
            send(ins, a, b, lat, bok, tmo);
            total_cnt++;
            if (tmo || lat != elat) $display("FAIL rand_lat[%0d] got %0d want %0d ins=%h", n, lat, elat, ins); else pass_cnt++;
            total_cnt++;
            if (bus.wb_data !== ed || bus.wb_illegal !== eill || bus.wb_we !== ewe || bus.wb_rd !== ins[11:7])
                $display("FAIL rand_res[%0d] ins=%h got data=%h ill=%b we=%b rd=%0d want %h/%b/%b/%0d",
                         n, ins, bus.wb_data, bus.wb_illegal, bus.wb_we, bus.wb_rd, ed, eill, ewe, ins[11:7]);
            else pass_cnt++;
            accept();
        end
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr    = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.wb_ready = 1'b0;
        test_reset();
        test_arith();
        test_shift();
        test_backpressure();
        test_illegal();
        test_rd0();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
